// File: rtl/nearest_neighbor_zoom_out_2x.sv
// 2x nearest-neighbour decimator: copies source pixel (2*ox, 2*oy)
// from the input RAM to output pixel (ox, oy), three cycles per pixel.
module nearest_neighbor_zoom_out_2x #(
    parameter int IMG_WIDTH_IN  = 160,
    parameter int IMG_HEIGHT_IN = 120,
    parameter int R_ADDR_W      = 15,
    parameter int W_ADDR_W      = 13
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [7:0]          pixel_in,
    output logic [R_ADDR_W-1:0] r_addr,
    output logic [7:0]          pixel_out,
    output logic [W_ADDR_W-1:0] w_addr,
    output logic                w_en,
    output logic                busy,
    output logic                done
);

    localparam int CW = 16;
    localparam logic [CW-1:0] OX_LAST = CW'(IMG_WIDTH_IN / 2 - 1);
    localparam logic [CW-1:0] OY_LAST = CW'(IMG_HEIGHT_IN / 2 - 1);
    localparam logic [R_ADDR_W-1:0] ROW_STEP = R_ADDR_W'(2 * IMG_WIDTH_IN);
    localparam logic [R_ADDR_W-1:0] COL_STEP = R_ADDR_W'(2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [R_ADDR_W-1:0]   r_addr_q, r_addr_d;
    logic [R_ADDR_W-1:0]   row_base_q, row_base_d;
    logic [CW-1:0]         ox_q, ox_d;
    logic [CW-1:0]         oy_q, oy_d;
    logic [W_ADDR_W-1:0]   w_addr_q, w_addr_d;
    logic [7:0]            pix_q, pix_d;
    logic                  w_en_q, w_en_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  last_col, last_row;

    assign last_col = (ox_q == OX_LAST);
    assign last_row = (oy_q == OY_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            r_addr_q   <= '0;
            row_base_q <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            w_addr_q   <= '0;
            pix_q      <= '0;
            w_en_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_addr_q   <= r_addr_d;
            row_base_q <= row_base_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            w_addr_q   <= w_addr_d;
            pix_q      <= pix_d;
            w_en_q     <= w_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        r_addr_d   = r_addr_q;
        row_base_d = row_base_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        w_addr_d   = w_addr_q;
        pix_d      = pix_q;
        w_en_d     = w_en_q;
        busy_d     = busy_q;
        done_d     = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    r_addr_d   = '0;
                    row_base_d = '0;
                    ox_d       = '0;
                    oy_d       = '0;
                    w_addr_d   = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    state_d    = ADDR;
                end
            end
            ADDR: state_d = WAIT;
            WAIT: begin
                pix_d   = pixel_in;
                w_en_d  = 1'b1;
                state_d = WRITE;
            end
            WRITE: begin
                w_en_d = 1'b0;
                if (last_col && last_row) begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    // next row starts two source rows further down
                    if (last_col) begin
                        ox_d       = '0;
                        oy_d       = oy_q + CW'(1);
                        row_base_d = row_base_q + ROW_STEP;
                        r_addr_d   = row_base_q + ROW_STEP;
                    end else begin
                        ox_d     = ox_q + CW'(1);
                        r_addr_d = r_addr_q + COL_STEP;
                    end
                    w_addr_d = w_addr_q + W_ADDR_W'(1);
                    state_d  = ADDR;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                w_en_d  = 1'b0;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign r_addr    = r_addr_q;
    assign pixel_out = pix_q;
    assign w_addr    = w_addr_q;
    assign w_en      = w_en_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_nearest_neighbor_zoom_out_2x.sv
// Bench for the 2x zoom-out engine: default 160x120 instance plus a
// 4x4 instance for fine timing and back-to-back frames.
module tb_nearest_neighbor_zoom_out_2x;

    typedef struct {
        int a;
        int d;
        int r;
        int c;
    } wr_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  pixel_in;
    logic [14:0] r_addr;
    logic [7:0]  pixel_out;
    logic [12:0] w_addr;
    logic        w_en, busy, done;

    logic        s_start;
    logic [7:0]  s_pixel_in;
    logic [3:0]  s_r_addr;
    logic [7:0]  s_pixel_out;
    logic [1:0]  s_w_addr;
    logic        s_w_en, s_busy, s_done;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int m_e0 = 0;
    int s_e0 = 0;
    logic [7:0] key = 8'h00;
    logic mb_prev = 1'b0;

    wr_t mq[$];
    wr_t sq[$];
    int  mdone[$];
    int  sdone[$];
    int  mbusy[$];

    nearest_neighbor_zoom_out_2x dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .pixel_in(pixel_in), .r_addr(r_addr), .pixel_out(pixel_out),
        .w_addr(w_addr), .w_en(w_en), .busy(busy), .done(done)
    );

    nearest_neighbor_zoom_out_2x #(
        .IMG_WIDTH_IN(4), .IMG_HEIGHT_IN(4), .R_ADDR_W(4), .W_ADDR_W(2)
    ) sdut (
        .clk(clk), .reset_n(reset_n), .start(s_start),
        .pixel_in(s_pixel_in), .r_addr(s_r_addr), .pixel_out(s_pixel_out),
        .w_addr(s_w_addr), .w_en(s_w_en), .busy(s_busy), .done(s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] f(input int a, input logic [7:0] k);
        int t;
        t = a ^ (a >> 8);
        return t[7:0] ^ k;
    endfunction

    always @(posedge clk) begin
        edge_n     <= edge_n + 1;
        pixel_in   <= f(int'(r_addr), key);
        s_pixel_in <= f(int'(s_r_addr), key);
    end

    // Log every write and completion, stamped relative to the frame origin.
    always @(negedge clk) begin
        if (w_en === 1'b1)
            mq.push_back('{int'(w_addr), int'(pixel_out), int'(r_addr), edge_n - m_e0});
        if (done === 1'b1)
            mdone.push_back(edge_n - m_e0);
        if (mb_prev && busy === 1'b0)
            mbusy.push_back(edge_n - m_e0);
        mb_prev <= (busy === 1'b1);
        if (s_w_en === 1'b1)
            sq.push_back('{int'(s_w_addr), int'(s_pixel_out), int'(s_r_addr), edge_n - s_e0});
        if (s_done === 1'b1)
            sdone.push_back(edge_n - s_e0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_writes(input string tag, input int w, input int n,
                                input int first, input int off, input wr_t q[$]);
        int src;
        for (int k = 0; k < n; k++) begin
            if (first + k >= q.size()) break;
            src = 2 * w * (k / (w / 2)) + 2 * (k % (w / 2));
            chk($sformatf("%s.waddr[%0d]", tag, k), q[first+k].a, k);
            chk($sformatf("%s.raddr[%0d]", tag, k), q[first+k].r, src);
            chk($sformatf("%s.pix[%0d]", tag, k), q[first+k].d, int'(f(src, key)));
            chk($sformatf("%s.cyc[%0d]", tag, k), q[first+k].c, off + 3 * k + 3);
        end
    endtask

    task automatic start_main();
        @(negedge clk);
        key = 8'($urandom_range(0, 255));
        mq.delete();
        mdone.delete();
        mbusy.delete();
        m_e0 = edge_n;
        start = 1'b1;
    endtask

    task automatic wait_main(input int p1, input int p2);
        int rel;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            rel = edge_n - m_e0;
            start = (rel == p1 || rel == p2);
            if (busy === 1'b0 && rel > 2) break;
        end
        start = 1'b0;
        chk("frame_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic check_main(input string tag);
        chk({tag, ".nwrites"}, mq.size(), 4800);
        chk({tag, ".ndone"}, mdone.size(), 1);
        chk({tag, ".nbusyfall"}, mbusy.size(), 1);
        if (mdone.size() > 0) chk({tag, ".done_cyc"}, mdone[0], 14401);
        if (mbusy.size() > 0) chk({tag, ".busy_low"}, mbusy[0], 14402);
        check_writes(tag, 160, 4800, 0, 0, mq);
    endtask

    initial begin
        int rel;
        reset_n = 1'b0;
        start   = 1'b0;
        s_start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.r_addr", r_addr, 0);
        chk("rst.w_addr", w_addr, 0);
        chk("rst.pixel_out", pixel_out, 0);
        chk("rst.w_en", w_en, 0);
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle.nwrites", mq.size(), 0);
        chk("idle.busy", busy, 0);

        // 4x4 instance, start held high across two frames
        key = 8'($urandom_range(0, 255));
        s_e0 = edge_n;
        s_start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (sdone.size() >= 2) break;
        end
        s_start = 1'b0;
        repeat (5) @(negedge clk);
        chk("small.nwrites", sq.size(), 8);
        chk("small.ndone", sdone.size(), 2);
        if (sdone.size() >= 2) begin
            chk("small.done0", sdone[0], 13);
            chk("small.done1", sdone[1], 27);
        end
        check_writes("small.f0", 4, 4, 0, 0, sq);
        check_writes("small.f1", 4, 4, 4, 14, sq);
        chk("small.busy_end", s_busy, 0);

        start_main();
        wait_main(-1, -1);
        check_main("frame1");

        start_main();
        wait_main(50, 7000);
        check_main("restart_ignored");

        // abort while w_en is high
        start_main();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start = 1'b0;
            rel = edge_n - m_e0;
            if (rel >= 501) break;
        end
        chk("abort.w_en_before", w_en, 1);
        #1 reset_n = 1'b0;
        #1;
        chk("abort.w_en", w_en, 0);
        chk("abort.busy", busy, 0);
        chk("abort.r_addr", r_addr, 0);
        chk("abort.done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort.idle_busy", busy, 0);

        start_main();
        wait_main(-1, -1);
        check_main("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
